// File: rtl/inst_fetch_stage_pkg.sv
// Shared fetch-stage types and constants: FSM encoding, reset vector, instruction width.
package inst_fetch_stage_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_stage_if_skid_buffer.sv
// One-entry {pc, inst} holding register that catches a fetched word while decode is stalled.
module if_skid_buffer
    import inst_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic [INST_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              valid_o,
    output logic [INST_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o
);

    logic              valid_q;
    logic [INST_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;

    // Load beats unload so a word arriving while the old one drains is kept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding, and presents a registered
// word to decode with a skid buffer for back-pressure and discard of responses killed by redirects.
module inst_fetch_stage
    import inst_fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    output logic              inst_req,
    output logic [INST_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [INST_W-1:0] inst_rdata,
    input  logic              redirect_valid,
    input  logic [INST_W-1:0] redirect_pc,
    input  logic              id_stall,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [INST_W-1:0] if_pc,
    output logic              if_adel
);

    fetch_state_t      state_q, state_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] req_pc_q, req_pc_d;
    logic              discard_q, discard_d;
    logic              adel_sent_q, adel_sent_d;

    logic              if_valid_q, if_adel_q;
    logic [INST_W-1:0] if_inst_q, if_pc_q;

    logic              buf_valid, buf_load, buf_unload;
    logic [INST_W-1:0] buf_pc, buf_inst;

    logic              pc_aligned, handshake, slot_free, rsp_keep, adel_go;
    logic              out_valid, out_adel;
    logic [INST_W-1:0] out_pc, out_inst;

    assign pc_aligned = (pc_q[1:0] == 2'b00);
    // Gating with resetn keeps the port quiet while reset is held.
    assign inst_req   = resetn & (state_q == REQ) & ~buf_valid & pc_aligned;
    assign inst_addr  = pc_q;
    assign handshake  = inst_req & inst_addr_ok;
    assign slot_free  = ~if_valid_q | ~id_stall;
    assign rsp_keep   = (state_q == WAIT) & inst_data_ok & ~discard_q & ~redirect_valid;
    assign adel_go    = (state_q == REQ) & ~pc_aligned & ~adel_sent_q & ~buf_valid
                      & slot_free & ~redirect_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        discard_d   = discard_q;
        adel_sent_d = adel_sent_q;
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            adel_sent_d = 1'b0;
            if (handshake) begin
                // The accepted address belongs to the old path; its data must be dropped.
                state_d   = WAIT;
                discard_d = 1'b1;
                req_pc_d  = pc_q;
            end else if (state_q == WAIT) begin
                if (inst_data_ok) begin
                    state_d   = REQ;
                    discard_d = 1'b0;
                end else begin
                    discard_d = 1'b1;
                end
            end
        end else begin
            if (handshake) begin
                pc_d     = pc_q + 32'd4;
                req_pc_d = pc_q;
                state_d  = WAIT;
            end
            if ((state_q == WAIT) && inst_data_ok) begin
                state_d   = REQ;
                discard_d = 1'b0;
            end
            if (adel_go) begin
                adel_sent_d = 1'b1;
            end
        end
    end

    // Buffered word always leaves first so program order is preserved.
    always_comb begin
        out_valid  = 1'b0;
        out_pc     = if_pc_q;
        out_inst   = if_inst_q;
        out_adel   = 1'b0;
        buf_load   = 1'b0;
        buf_unload = 1'b0;
        if (!redirect_valid) begin
            if (slot_free) begin
                if (buf_valid) begin
                    out_valid  = 1'b1;
                    out_pc     = buf_pc;
                    out_inst   = buf_inst;
                    buf_unload = 1'b1;
                    buf_load   = rsp_keep;
                end else if (rsp_keep) begin
                    out_valid = 1'b1;
                    out_pc    = req_pc_q;
                    out_inst  = inst_rdata;
                end else if (adel_go) begin
                    out_valid = 1'b1;
                    out_pc    = pc_q;
                    out_inst  = '0;
                    out_adel  = 1'b1;
                end
            end else begin
                buf_load = rsp_keep;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            discard_q   <= 1'b0;
            adel_sent_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            discard_q   <= discard_d;
            adel_sent_q <= adel_sent_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            if_pc_q    <= '0;
            if_adel_q  <= 1'b0;
        end else if (redirect_valid) begin
            if_valid_q <= 1'b0;
            if_adel_q  <= 1'b0;
        end else if (slot_free) begin
            if_valid_q <= out_valid;
            if (out_valid) begin
                if_pc_q   <= out_pc;
                if_inst_q <= out_inst;
                if_adel_q <= out_adel;
            end
        end
    end

    if_skid_buffer u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .flush_i  (redirect_valid),
        .load_i   (buf_load),
        .unload_i (buf_unload),
        .pc_i     (req_pc_q),
        .inst_i   (inst_rdata),
        .valid_o  (buf_valid),
        .pc_o     (buf_pc),
        .inst_o   (buf_inst)
    );

    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign if_pc    = if_pc_q;
    assign if_adel  = if_adel_q;

endmodule
